// File: rtl/cook_time_entry.sv
// cook_time_entry: cook-time keypad entry with debounced buttons, digit cursor editing and PROG/RUN control.
// Define COOK_TIME_AUTO_REPEAT_EN to enable auto-repeat on held up/down buttons.
module cook_time_entry #(
  parameter int DEBOUNCE_TICKS = 10,
  parameter int REPEAT_DELAY = 250,
  parameter int REPEAT_PERIOD = 50
) (
  input  logic       clk_5MHz,
  input  logic       reset,
  input  logic       pulse_2ms,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_next,
  input  logic       btn_start,
  input  logic       timer_done,
  output logic [3:0] seconds_prog,
  output logic [3:0] tens_seconds_prog,
  output logic [3:0] minutes_prog,
  output logic [3:0] tens_minutes_prog,
  output logic [1:0] cursor,
  output logic       display_prog,
  output logic       load_pulse
);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  typedef enum logic {RUN = 1'b0, PROG = 1'b1} state_t;
  state_t state_q, state_d;
  logic [3:0] raw, sync1_q, sync2_q, lvl_q, lvl_d, prev_q, press;
  logic [DW-1:0] cnt_q [4];
  logic [DW-1:0] cnt_d [4];
  logic [3:0] dig_q [4];
  logic [3:0] dig_d [4];
  logic [3:0] sel, lim;
  logic [1:0] cursor_q, cursor_d;
  logic load_q, load_d, up_raw, dn_raw, up_evt, dn_evt;
  assign raw = {btn_start, btn_next, btn_down, btn_up};
  // Bit order everywhere: 0=up, 1=down, 2=next, 3=start
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (pulse_2ms) begin
        if (sync2_q[i] == lvl_q[i]) cnt_d[i] = '0;
        else if (cnt_q[i] == DW'(DEBOUNCE_TICKS - 1)) begin
          cnt_d[i] = '0;
          lvl_d[i] = sync2_q[i];
        end else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
  assign press = lvl_q & ~prev_q;
`ifdef COOK_TIME_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [RW-1:0] rep_q, rep_d;
  logic rep_evt;
  // Restart the delay whenever the held direction is not unique or a fresh press arrives
  always_comb begin
    rep_d = rep_q;
    rep_evt = 1'b0;
    if (state_q != PROG || lvl_q[0] == lvl_q[1] || press[0] || press[1]) rep_d = '0;
    else if (pulse_2ms) begin
      if (rep_q == RW'(REPEAT_DELAY - 1)) begin
        rep_evt = 1'b1;
        rep_d = RW'(REPEAT_DELAY - REPEAT_PERIOD);
      end else rep_d = rep_q + 1'b1;
    end
  end
  always_ff @(posedge clk_5MHz) rep_q <= reset ? '0 : rep_d;
  assign up_raw = press[0] | (rep_evt & lvl_q[0]);
  assign dn_raw = press[1] | (rep_evt & lvl_q[1]);
`else
  localparam int unused_repeat = REPEAT_DELAY + REPEAT_PERIOD;
  assign up_raw = press[0];
  assign dn_raw = press[1];
`endif
  assign up_evt = up_raw & ~dn_raw;
  assign dn_evt = dn_raw & ~up_raw;
  always_comb begin
    state_d = state_q;
    cursor_d = cursor_q;
    dig_d = dig_q;
    load_d = 1'b0;
    sel = dig_q[cursor_q];
    lim = cursor_q == 2'd1 ? 4'd5 : 4'd9;
    if (state_q == PROG) begin
      if (up_evt) dig_d[cursor_q] = sel == lim ? 4'd0 : sel + 4'd1;
      else if (dn_evt) dig_d[cursor_q] = sel == 4'd0 ? lim : sel - 4'd1;
      if (press[2]) cursor_d = cursor_q + 2'd1;
      if (press[3] && |{dig_q[0], dig_q[1], dig_q[2], dig_q[3]}) begin
        state_d = RUN;
        load_d = 1'b1;
      end
    end else if (press[3] || timer_done) state_d = PROG;
  end
  always_ff @(posedge clk_5MHz) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q <= '0;
      prev_q <= '0;
      cnt_q <= '{default: '0};
      dig_q <= '{default: '0};
      cursor_q <= '0;
      state_q <= PROG;
      load_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      lvl_q <= lvl_d;
      prev_q <= lvl_q;
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      cursor_q <= cursor_d;
      state_q <= state_d;
      load_q <= load_d;
    end
  end
  assign seconds_prog = dig_q[0];
  assign tens_seconds_prog = dig_q[1];
  assign minutes_prog = dig_q[2];
  assign tens_minutes_prog = dig_q[3];
  assign cursor = cursor_q;
  assign display_prog = state_q == PROG;
  assign load_pulse = load_q;
endmodule

// File: tb/tb_cook_time_entry.sv
// tb_cook_time_entry: directed table, hand-written corner sequences and randomized ops against a digit-level model.
module tb_cook_time_entry;
  localparam int DB = 10;
  localparam int PER = 4;
  logic clk_5MHz = 1'b0, reset = 1'b1, pulse_2ms = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_next = 1'b0, btn_start = 1'b0, timer_done = 1'b0;
  logic [3:0] seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog;
  logic [1:0] cursor;
  logic display_prog, load_pulse;
  int checks = 0, failures = 0, load_cnt = 0;
  logic load_prev = 1'b0;
  int ph = 0;
  int m_dig[4];
  int m_cur, m_loads;
  bit m_prog;

  cook_time_entry dut (
    .clk_5MHz(clk_5MHz), .reset(reset), .pulse_2ms(pulse_2ms),
    .btn_up(btn_up), .btn_down(btn_down), .btn_next(btn_next), .btn_start(btn_start),
    .timer_done(timer_done), .seconds_prog(seconds_prog), .tens_seconds_prog(tens_seconds_prog),
    .minutes_prog(minutes_prog), .tens_minutes_prog(tens_minutes_prog), .cursor(cursor),
    .display_prog(display_prog), .load_pulse(load_pulse)
  );

  always #5 clk_5MHz = ~clk_5MHz;

  initial forever begin
    @(negedge clk_5MHz);
    pulse_2ms = (ph == PER - 1);
    ph = (ph + 1) % PER;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk_5MHz) begin
    if (!reset && load_pulse) begin
      load_cnt++;
      check("load_display_run", int'(display_prog), 0);
      check("load_single_cycle", int'(load_prev), 0);
    end
    load_prev = load_pulse;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_5MHz);
  endtask

  task automatic ticks(input int n);
    cycles(n * PER);
  endtask

  task automatic set_btns(input int b);
    btn_up = b[0];
    btn_down = b[1];
    btn_next = b[2];
    btn_start = b[3];
  endtask

  task automatic reset_dut();
    set_btns(0);
    timer_done = 1'b0;
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    load_cnt = 0;
    m_dig = '{0, 0, 0, 0};
    m_cur = 0;
    m_prog = 1'b1;
    m_loads = 0;
  endtask

  task automatic hold(input int b, input int t);
    set_btns(b);
    ticks(t);
    set_btns(0);
    ticks(DB + 3);
  endtask

  // ops: 0 up, 1 down, 2 next, 3 start, 4 timer_done, 5 short bounce on up, 6 up+down together
  task automatic do_op(input int op);
    if (op == 4) begin
      timer_done = 1'b1;
      cycles(1);
      timer_done = 1'b0;
      cycles(2);
    end else if (op == 5) hold(1, 7);
    else hold(op == 6 ? 3 : (1 << op), DB + 2);
  endtask

  function automatic int lim(input int c);
    return c == 1 ? 6 : 10;
  endfunction

  task automatic model_op(input int op);
    if (op == 4 || op == 5 || op == 6) begin
      if (op == 4) m_prog = 1'b1;
    end else if (!m_prog) begin
      if (op == 3) m_prog = 1'b1;
    end else if (op == 0) m_dig[m_cur] = (m_dig[m_cur] + 1) % lim(m_cur);
    else if (op == 1) m_dig[m_cur] = (m_dig[m_cur] + lim(m_cur) - 1) % lim(m_cur);
    else if (op == 2) m_cur = (m_cur + 1) % 4;
    else if (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3] != 0) begin
      m_prog = 1'b0;
      m_loads++;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sec"}, int'(seconds_prog), m_dig[0]);
    check({tag, ".tsec"}, int'(tens_seconds_prog), m_dig[1]);
    check({tag, ".min"}, int'(minutes_prog), m_dig[2]);
    check({tag, ".tmin"}, int'(tens_minutes_prog), m_dig[3]);
    check({tag, ".cursor"}, int'(cursor), m_cur);
    check({tag, ".display"}, int'(display_prog), int'(m_prog));
    check({tag, ".loads"}, load_cnt, m_loads);
  endtask

  typedef struct {
    int op;
    int reps;
    logic [15:0] dig;
    int cur;
    bit prog;
    int loads;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int n;
    int exp_rep;
    tbl = '{
      '{3, 1, 16'h0000, 0, 1'b1, 0},
      '{0, 9, 16'h0009, 0, 1'b1, 0},
      '{0, 1, 16'h0000, 0, 1'b1, 0},
      '{2, 1, 16'h0000, 1, 1'b1, 0},
      '{1, 1, 16'h0050, 1, 1'b1, 0},
      '{0, 1, 16'h0000, 1, 1'b1, 0},
      '{2, 2, 16'h0000, 3, 1'b1, 0},
      '{0, 1, 16'h1000, 3, 1'b1, 0},
      '{1, 2, 16'h9000, 3, 1'b1, 0},
      '{2, 1, 16'h9000, 0, 1'b1, 0},
      '{1, 1, 16'h9009, 0, 1'b1, 0},
      '{5, 1, 16'h9009, 0, 1'b1, 0},
      '{6, 1, 16'h9009, 0, 1'b1, 0},
      '{3, 1, 16'h9009, 0, 1'b0, 1},
      '{0, 1, 16'h9009, 0, 1'b0, 1},
      '{2, 1, 16'h9009, 0, 1'b0, 1},
      '{4, 1, 16'h9009, 0, 1'b1, 1},
      '{3, 1, 16'h9009, 0, 1'b0, 2},
      '{3, 1, 16'h9009, 0, 1'b1, 2},
      '{4, 1, 16'h9009, 0, 1'b1, 2}
    };
    reset_dut();
    check("reset.load", int'(load_pulse), 0);
    check_all("reset");

    // press latency, then bounce patterns that must not register
    btn_up = 1'b1;
    n = 0;
    while (seconds_prog == 4'd0 && n < 200) begin
      cycles(1);
      n++;
    end
    check("up_latency_in_window", int'(n >= 39 && n <= 44), 1);
    ticks(3);
    btn_up = 1'b0;
    ticks(DB + 3);
    check("single_press.sec", int'(seconds_prog), 1);
    hold(1, 7);
    check("bounce7.sec", int'(seconds_prog), 1);
    set_btns(1);
    ticks(6);
    set_btns(0);
    ticks(1);
    hold(1, 6);
    check("bounce_gap.sec", int'(seconds_prog), 1);

    // reset mid-debounce discards the count; held button re-debounces afterwards
    reset_dut();
    btn_up = 1'b1;
    ticks(6);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    ticks(7);
    check("rst_mid_db.early", int'(seconds_prog), 0);
    ticks(6);
    check("rst_mid_db.late", int'(seconds_prog), 1);
    btn_up = 1'b0;
    ticks(DB + 3);

    // 00:30 start/timer_done round trip
    reset_dut();
    do_op(2);
    repeat (3) do_op(0);
    do_op(3);
    check("0030.load_count", load_cnt, 1);
    check("0030.display_run", int'(display_prog), 0);
    do_op(4);
    check("0030.display_prog", int'(display_prog), 1);
    check("0030.tsec", int'(tens_seconds_prog), 3);
    check("0030.sec", int'(seconds_prog), 0);

    // directed table from reset
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      repeat (tbl[i].reps) do_op(tbl[i].op);
      check($sformatf("tbl%0d.sec", i), int'(seconds_prog), int'(tbl[i].dig[3:0]));
      check($sformatf("tbl%0d.tsec", i), int'(tens_seconds_prog), int'(tbl[i].dig[7:4]));
      check($sformatf("tbl%0d.min", i), int'(minutes_prog), int'(tbl[i].dig[11:8]));
      check($sformatf("tbl%0d.tmin", i), int'(tens_minutes_prog), int'(tbl[i].dig[15:12]));
      check($sformatf("tbl%0d.cursor", i), int'(cursor), tbl[i].cur);
      check($sformatf("tbl%0d.display", i), int'(display_prog), int'(tbl[i].prog));
      check($sformatf("tbl%0d.loads", i), load_cnt, tbl[i].loads);
    end

    // randomized ops against the model
    reset_dut();
    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op > 6) op = $urandom_range(0, 2);
      do_op(op);
      model_op(op);
      check_all($sformatf("rnd%0d_op%0d", i, op));
    end

    // long hold: auto-repeat only when enabled
    reset_dut();
`ifdef COOK_TIME_AUTO_REPEAT_EN
    exp_rep = 4;
`else
    exp_rep = 1;
`endif
    btn_up = 1'b1;
    ticks(370);
    btn_up = 1'b0;
    ticks(DB + 3);
    check("long_hold.sec", int'(seconds_prog), exp_rep);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
